// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers the decoded instruction, resolves operand
// forwarding from EX/MEM and MEM/WB, selects register or immediate for the
// second ALU operand, and detects load-use hazards that stall decode.
module id_ex_stage #(
  parameter int width    = 32,
  parameter int regAddrW = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                idValid,
  input  logic [regAddrW-1:0] idRs1Addr,
  input  logic [regAddrW-1:0] idRs2Addr,
  input  logic [width-1:0]    idRs1Data,
  input  logic [width-1:0]    idRs2Data,
  input  logic [width-1:0]    idImm,
  input  logic                idAluSrc,
  input  logic [3:0]          idFunc,
  input  logic [2:0]          idAluOp,
  input  logic [regAddrW-1:0] idRd,
  input  logic                idRegWrite,
  input  logic                idMemRead,
  input  logic [regAddrW-1:0] exMemRd,
  input  logic [regAddrW-1:0] memWbRd,
  input  logic                exMemRegWrite,
  input  logic                memWbRegWrite,
  input  logic [width-1:0]    exMemResult,
  input  logic [width-1:0]    memWbResult,
  input  logic                flush,
  output logic                stallId,
  output logic [width-1:0]    dataA,
  output logic [width-1:0]    dataB,
  output logic [3:0]          func,
  output logic [2:0]          aluOp,
  output logic [regAddrW-1:0] exRd,
  output logic                exRegWrite,
  output logic                exMemRead,
  output logic                exValid,
  output logic [width-1:0]    exStoreData
);

  // All pipeline fields travel together; an all-zero value is a bubble.
  typedef struct packed {
    logic                valid;
    logic [regAddrW-1:0] rs1_addr;
    logic [regAddrW-1:0] rs2_addr;
    logic [width-1:0]    rs1_data;
    logic [width-1:0]    rs2_data;
    logic [width-1:0]    imm;
    logic                alu_src;
    logic [3:0]          func;
    logic [2:0]          alu_op;
    logic [regAddrW-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } id_ex_t;

  id_ex_t ex_d, ex_q;
  logic   rs_match;
  logic [width-1:0] fwd_a, fwd_b;

  // Load-use hazard: the load in EX cannot forward yet, so decode waits one cycle.
  // A flushed decode instruction is killed anyway and never needs the stall.
  always_comb begin
    rs_match = (ex_q.rd == idRs1Addr) || (ex_q.rd == idRs2Addr);
    stallId  = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && idValid &&
               rs_match && !flush;
  end

  // Next-state: bubble on flush, stall or empty decode; otherwise capture decode.
  always_comb begin
    // NOTE: default assigned first so every path drives ex_d and no latch is inferred.
    ex_d = '0;
    if (!(flush || stallId || !idValid)) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1_addr  = idRs1Addr;
      ex_d.rs2_addr  = idRs2Addr;
      ex_d.rs1_data  = idRs1Data;
      ex_d.rs2_data  = idRs2Data;
      ex_d.imm       = idImm;
      ex_d.alu_src   = idAluSrc;
      ex_d.func      = idFunc;
      ex_d.alu_op    = idAluOp;
      ex_d.rd        = idRd;
      ex_d.reg_write = idRegWrite;
      ex_d.mem_read  = idMemRead;
    end
  end

  // Pipeline register with synchronous reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps the register update order-independent.
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Operand forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
  function automatic logic [width-1:0] forward(input logic [regAddrW-1:0] addr,
                                               input logic [width-1:0]    reg_data);
    if (exMemRegWrite && (exMemRd != '0) && (exMemRd == addr))
      return exMemResult;
    else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == addr))
      return memWbResult;
    else
      return reg_data;
  endfunction

  // ALU operands and store data, combinational from the register and forwarding inputs.
  always_comb begin
    fwd_a       = forward(ex_q.rs1_addr, ex_q.rs1_data);
    fwd_b       = forward(ex_q.rs2_addr, ex_q.rs2_data);
    dataA       = fwd_a;
    dataB       = ex_q.alu_src ? ex_q.imm : fwd_b;
    exStoreData = fwd_b;
  end

  assign func       = ex_q.func;
  assign aluOp      = ex_q.alu_op;
  assign exRd       = ex_q.rd;
  assign exRegWrite = ex_q.reg_write;
  assign exMemRead  = ex_q.mem_read;
  assign exValid    = ex_q.valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RISC-V core, sitting directly upstream of the ALU. It registers the decoded instruction, resolves operand forwarding from the EX/MEM and MEM/WB stages, and selects register or immediate for the second operand. It drives the ALU's `dataA`, `dataB`, `func` and `aluOp`. It also detects load-use hazards, stalls decode, and inserts bubbles on hazard or branch flush.

## Interface
- `width`, 32, datapath width
- `regAddrW`, 5, register address width

Ports:
- `clk`  in  1  rising-edge clock (single clock domain)
- `reset`  in  1  synchronous, active-high reset
- `idValid`  in  1  decode holds a valid instruction
- `idRs1Addr`, `idRs2Addr`  in  regAddrW  source register addresses
- `idRs1Data`, `idRs2Data`  in  width  register-file read data
- `idImm`  in  width  sign-extended immediate
- `idAluSrc`  in  1  1 = `dataB` takes the immediate
- `idFunc`  in  4  ALU function code {funct7[5], funct3}
- `idAluOp`  in  3  ALU operation class
- `idRd`  in  regAddrW  destination register
- `idRegWrite`, `idMemRead`  in  1  write-back enable, load flag
- `exMemRd`, `memWbRd`  in  regAddrW  destinations of the two downstream stages
- `exMemRegWrite`, `memWbRegWrite`  in  1  downstream write enables
- `exMemResult`, `memWbResult`  in  width  downstream results
- `flush`  in  1  branch taken; kill the instruction in decode
- `stallId`  out  1  hold PC and IF/ID this cycle
- `dataA`, `dataB`  out  width  ALU operands
- `func`  out  4  to ALU
- `aluOp`  out  3  to ALU
- `exRd`  out  regAddrW  registered destination
- `exRegWrite`, `exMemRead`, `exValid`  out  1  registered controls
- `exStoreData`  out  width  forwarded rs2 value for stores

## Operation
- Register fields: valid, rs1/rs2 addresses, rs1/rs2 data, imm, aluSrc, func, aluOp, rd, regWrite, memRead.
- Load-use hazard (combinational): `stallId` = `exValid & exMemRead & (exRd != 0) & idValid & ((exRd == idRs1Addr) | (exRd == idRs2Addr)) & ~flush`.
- Register update at each rising edge, in priority order:
  - `reset`: all fields 0.
  - `flush` or `stallId`: bubble, all fields 0.
  - `idValid` = 0: bubble.
  - Otherwise: capture the id* inputs.
- Forwarding applies independently to rs1 (producing `dataA`) and rs2 (producing `fwdB`):
  - If EX/MEM write is enabled, its rd ≠ 0, and it equals the source address, select `exMemResult`.
  - Else if MEM/WB write is enabled, its rd ≠ 0, and it equals the source address, select `memWbResult`.
  - Else select the registered read data.
- EX/MEM has priority over MEM/WB. Register address 0 is never forwarded.
- `dataB` = `aluSrc ? imm : fwdB`. `exStoreData` = `fwdB` regardless of `aluSrc`.
- `func`, `aluOp`, `exRd`, `exRegWrite`, `exMemRead`, `exValid` are direct register outputs.
- A bubble has all fields zero, so it yields `dataA` = `dataB` = 0, `aluOp` = 000 (ALU computes 0 + 0) and `exRegWrite` = 0. A bubble therefore has no architectural effect.
- No arithmetic is performed in this block; all data is passed through at full `width`, with no truncation.

## Timing
- Latency: id* inputs sampled at edge N appear on the outputs after edge N.
- `dataA`, `dataB` and `exStoreData` are combinational from register contents and the current-cycle forwarding inputs. Forwarding values must settle within the same cycle.
- `stallId` is combinational in the same cycle as the offending decode inputs.
  - Decode must hold its inputs while `stallId` = 1.
  - Exactly one bubble is inserted per load-use hazard. In the next cycle the load is in EX/MEM and `stallId` drops; no load-to-use forwarding is required.
- `flush` and `stallId` asserted together: `stallId` is forced to 0 and a bubble is inserted (the killed instruction needs no stall).
- `reset` asserted mid-operation: all outputs are 0 after the next edge and `stallId` = 0.
  - Reset values: every register output is 0. `dataA`/`dataB`/`exStoreData` are 0 unless forwarding inputs are active. `stallId` = 0.

## Test plan
- Reset: assert `reset` for 2 cycles with random id* inputs -> all outputs 0 and `stallId` = 0.
- Immediate path: rs1Data = 0x10, imm = 0xFFFFFFFC, aluSrc = 1, aluOp = 000, no forwarding -> next cycle `dataA` = 0x10, `dataB` = 0xFFFFFFFC.
- Forward priority: registered rs1 = x5 (data 0x1), exMemRd = 5 (result 0xAA, write enabled), memWbRd = 5 (result 0xBB, write enabled) -> `dataA` = 0xAA. Disable exMemRegWrite -> `dataA` = 0xBB. Disable both -> 0x1.
- x0 guard: rs2 = x0, exMemRd = 0, exMemRegWrite = 1, result 0x55, aluSrc = 0 -> `dataB` = 0 and `exStoreData` = 0.
- Load-use: load to x7 sits in the register, decode presents rs1 = x7 -> `stallId` = 1 for exactly one cycle and a bubble is inserted (`exValid` = 0, `aluOp` = 000). The held instruction is captured on the following edge.
- Flush during stall: load-use condition with `flush` = 1 -> `stallId` = 0 and the next cycle holds a bubble (`exRegWrite` = 0).
